rf_wb_arbiter: RTL and testbench

Shares the register file's single write port (Rd / writeData / we) between two writeback sources: the ALU result path and the memory-load path. Each source hands over results through a valid/ready handshake into its own small FIFO. A fixed-priority arbiter selects one entry per cycle and drives registered write signals into the register file. A halt sequencer drains all pending writes before raising the halt line to the register file, so the final register dump reflects every accepted result.

---
 rtl/rf_wb_pkg.sv | 27 ++
 rtl/rf_wb_fifo.sv | 71 +++++++
 rtl/rf_wb_arbiter.sv | 179 +++++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_pkg.sv
// rf_wb_pkg: shared types and constants for the register-file writeback arbiter.
//   DATA_W / ADDR_W : register data width and register index width
//   wb_entry_t      : one pending writeback {rd, data}
//   fsm_state_t     : RUN / DRAIN / HALTED halt sequencer states
//   src_t           : writeback source identifier, also used as the FIFO index
package rf_wb_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } fsm_state_t;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// rf_wb_fifo: small synchronous FIFO of wb_entry_t with wrap-around pointers.
//   clk, srst          : clock, synchronous active-high reset (empties FIFO)
//   push, push_entry   : write an entry (ignored when full)
//   pop                : drop the head entry (ignored when empty)
//   head               : current head entry (valid when !empty)
//   full, empty, count : occupancy, all derived from the registered count
module rf_wb_fifo
    import rf_wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       srst,
    input  logic                       push,
    input  wb_entry_t                  push_entry,
    input  logic                       pop,
    output wb_entry_t                  head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t          mem_reg [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;

    logic push_ok;
    logic pop_ok;

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // The head is read straight from storage; the consumer registers it.
    assign head = mem_reg[rd_ptr_reg];

    // Storage carries no reset so it can map onto plain memory.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_reg[wr_ptr_reg] <= push_entry;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the register-file write port between the ALU result
// path and the memory-load path, and drains pending writes before halting.
//   clk, rst                        : clock, synchronous active-high reset
//   alu_valid/ready/rd/data         : ALU writeback handshake
//   mem_valid/ready/rd/data         : load writeback handshake
//   halt_req                        : halt request (level or pulse)
//   rf_we, rf_rd, rf_wdata          : registered register-file write port
//   rf_hlt                          : registered halt to register file
//   busy                            : FIFO non-empty or write in flight
//   wr_count                        : committed writes to rd!=0, saturating
// Build option: define RF_WB_ROUND_ROBIN_EN for round-robin arbitration;
// otherwise the load path has fixed priority over the ALU path.
module rf_wb_arbiter
    import rf_wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              halt_req,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_rd,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              rf_hlt,
    output logic              busy,
    output logic [15:0]       wr_count
);

    localparam int NSRC  = 2;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    fsm_state_t         state_reg;
    logic               rf_we_reg;
    logic [ADDR_W-1:0]  rf_rd_reg;
    logic [DATA_W-1:0]  rf_wdata_reg;
    logic               rf_hlt_reg;
    logic [15:0]        wr_count_reg;

    logic [NSRC-1:0]    in_valid;
    logic [NSRC-1:0]    in_ready;
    logic [NSRC-1:0]    push;
    logic [NSRC-1:0]    pop;
    logic [NSRC-1:0]    full;
    logic [NSRC-1:0]    empty;
    wb_entry_t          in_entry [NSRC];
    wb_entry_t          head     [NSRC];
    logic [CNT_W-1:0]   count    [NSRC];

    src_t               grant;
    logic               grant_valid;
    wb_entry_t          sel_entry;
    logic               write_next;
    logic               drained;

    assign in_valid[SRC_ALU] = alu_valid;
    assign in_valid[SRC_MEM] = mem_valid;
    assign in_entry[SRC_ALU] = '{rd: alu_rd, data: alu_data};
    assign in_entry[SRC_MEM] = '{rd: mem_rd, data: mem_data};

    genvar gi;
    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_src
            // Ready depends only on registered state, never on this cycle's pop.
            assign in_ready[gi] = (state_reg == RUN) && !full[gi];
            assign push[gi]     = in_valid[gi] && in_ready[gi];

            rf_wb_fifo #(
                .DEPTH(DEPTH)
            ) u_fifo (
                .clk        (clk),
                .srst       (rst),
                .push       (push[gi]),
                .push_entry (in_entry[gi]),
                .pop        (pop[gi]),
                .head       (head[gi]),
                .full       (full[gi]),
                .empty      (empty[gi]),
                .count      (count[gi])
            );
        end
    endgenerate

    assign alu_ready = in_ready[SRC_ALU];
    assign mem_ready = in_ready[SRC_MEM];

    assign grant_valid = !empty[SRC_ALU] || !empty[SRC_MEM];

`ifdef RF_WB_ROUND_ROBIN_EN
    src_t last_grant_reg;

    // On contention the source that did not win last time is served.
    always_comb begin
        grant = SRC_ALU;
        if (!empty[SRC_ALU] && !empty[SRC_MEM]) begin
            grant = (last_grant_reg == SRC_ALU) ? SRC_MEM : SRC_ALU;
        end else if (!empty[SRC_MEM]) begin
            grant = SRC_MEM;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_reg <= SRC_ALU;
        end else if (grant_valid) begin
            last_grant_reg <= grant;
        end
    end
`else
    // Loads always win over ALU results.
    always_comb begin
        grant = empty[SRC_MEM] ? SRC_ALU : SRC_MEM;
    end
`endif

    assign pop[SRC_ALU] = grant_valid && (grant == SRC_ALU);
    assign pop[SRC_MEM] = grant_valid && (grant == SRC_MEM);
    assign sel_entry    = head[grant];

    // Entries for r0 are consumed but never written.
    assign write_next = grant_valid && (sel_entry.rd != '0);
    assign drained    = empty[SRC_ALU] && empty[SRC_MEM] && !rf_we_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= RUN;
            rf_we_reg    <= 1'b0;
            rf_rd_reg    <= '0;
            rf_wdata_reg <= '0;
            rf_hlt_reg   <= 1'b0;
            wr_count_reg <= '0;
        end else begin
            rf_we_reg <= write_next;
            if (write_next) begin
                rf_rd_reg    <= sel_entry.rd;
                rf_wdata_reg <= sel_entry.data;
            end

            if (rf_we_reg && (wr_count_reg != 16'hFFFF)) begin
                wr_count_reg <= wr_count_reg + 16'd1;
            end

            case (state_reg)
                RUN: begin
                    if (halt_req) begin
                        state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drained) begin
                        state_reg  <= HALTED;
                        rf_hlt_reg <= 1'b1;
                    end
                end
                HALTED: begin
                    rf_hlt_reg <= 1'b1;
                end
                default: begin
                    state_reg <= RUN;
                end
            endcase
        end
    end

    assign rf_we    = rf_we_reg;
    assign rf_rd    = rf_rd_reg;
    assign rf_wdata = rf_wdata_reg;
    assign rf_hlt   = rf_hlt_reg;
    assign wr_count = wr_count_reg;
    assign busy     = (count[SRC_ALU] != '0) || (count[SRC_MEM] != '0) || rf_we_reg;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: self-checking bench for rf_wb_arbiter.
// A queue-based reference model tracks both FIFOs, the write stream, the
// halt sequence and the write counter; outputs are compared every cycle on
// the falling edge. Directed sequences add hand-computed literal checks.
// Honours RF_WB_ROUND_ROBIN_EN to pick the expected arbitration policy.
module tb_rf_wb_arbiter;

    localparam int DEPTH = 2;

`ifdef RF_WB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_valid = 1'b0;
    logic        alu_ready;
    logic [3:0]  alu_rd = 4'd0;
    logic [15:0] alu_data = 16'd0;
    logic        mem_valid = 1'b0;
    logic        mem_ready;
    logic [3:0]  mem_rd = 4'd0;
    logic [15:0] mem_data = 16'd0;
    logic        halt_req = 1'b0;
    logic        rf_we;
    logic [3:0]  rf_rd;
    logic [15:0] rf_wdata;
    logic        rf_hlt;
    logic        busy;
    logic [15:0] wr_count;

    rf_wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_rd    (mem_rd),
        .mem_data  (mem_data),
        .halt_req  (halt_req),
        .rf_we     (rf_we),
        .rf_rd     (rf_rd),
        .rf_wdata  (rf_wdata),
        .rf_hlt    (rf_hlt),
        .busy      (busy),
        .wr_count  (wr_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // mode: 0 = running, 1 = draining, 2 = halted
    logic [19:0] aq[$];
    logic [19:0] mq[$];
    int          m_mode = 0;
    logic        m_we = 1'b0;
    logic [3:0]  m_rd = 4'd0;
    logic [15:0] m_wd = 16'd0;
    logic [15:0] m_cnt = 16'd0;
    logic        m_hlt = 1'b0;
    logic        m_last = 1'b0;   // 0 = ALU served last, 1 = load served last
    logic        m_done, m_acc_a, m_acc_m, m_take_mem;
    logic [19:0] m_e;

    always @(posedge clk) begin
        if (rst) begin
            aq.delete();
            mq.delete();
            m_mode = 0;
            m_we   = 1'b0;
            m_rd   = 4'd0;
            m_wd   = 16'd0;
            m_cnt  = 16'd0;
            m_hlt  = 1'b0;
            m_last = 1'b0;
        end else begin
            m_done  = (m_mode == 1) && (aq.size() == 0) && (mq.size() == 0) && !m_we;
            m_acc_a = alu_valid && (m_mode == 0) && (aq.size() < DEPTH);
            m_acc_m = mem_valid && (m_mode == 0) && (mq.size() < DEPTH);
            if (m_we && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            m_we = 1'b0;
            if (mq.size() > 0 || aq.size() > 0) begin
                if (mq.size() > 0 && aq.size() > 0) m_take_mem = RR ? !m_last : 1'b1;
                else                                m_take_mem = (mq.size() > 0);
                m_e    = m_take_mem ? mq.pop_front() : aq.pop_front();
                m_last = m_take_mem;
                if (m_e[19:16] != 4'd0) begin
                    m_we = 1'b1;
                    m_rd = m_e[19:16];
                    m_wd = m_e[15:0];
                end
            end
            if (m_acc_a) aq.push_back({alu_rd, alu_data});
            if (m_acc_m) mq.push_back({mem_rd, mem_data});
            if (m_mode == 0 && halt_req) m_mode = 1;
            else if (m_done)             m_mode = 2;
            m_hlt = (m_mode == 2);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (check_en) begin
            chk("alu_ready", alu_ready, (m_mode == 0) && (aq.size() < DEPTH));
            chk("mem_ready", mem_ready, (m_mode == 0) && (mq.size() < DEPTH));
            chk("rf_we", rf_we, m_we);
            if (m_we) begin
                chk("rf_rd", rf_rd, m_rd);
                chk("rf_wdata", rf_wdata, m_wd);
            end
            chk("rf_hlt", rf_hlt, m_hlt);
            chk("busy", busy, (aq.size() > 0) || (mq.size() > 0) || m_we);
            chk("wr_count", wr_count, m_cnt);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic idle();
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        halt_req  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    // Two cycles of both sources offering, halt raised on the second.
    task automatic fill_and_halt();
        alu_valid = 1'b1; alu_rd = 4'd1; alu_data = 16'hC001;
        mem_valid = 1'b1; mem_rd = 4'd2; mem_data = 16'hD002;
        cyc();
        alu_rd = 4'd6; alu_data = 16'hC006;
        mem_rd = 4'd7; mem_data = 16'hD007;
        halt_req = 1'b1;
        cyc();
        idle();
    endtask

    logic [3:0] seq[$];
    int nwr;
    bit got;

    initial begin
        @(posedge clk);
        #1 check_en = 1'b1;
        do_reset();

        // reset values
        chk("rst_we", rf_we, 1'b0);
        chk("rst_rd", rf_rd, 4'd0);
        chk("rst_wdata", rf_wdata, 16'd0);
        chk("rst_hlt", rf_hlt, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_cnt", wr_count, 16'd0);
        chk("rst_alu_ready", alu_ready, 1'b1);
        chk("rst_mem_ready", mem_ready, 1'b1);
        $display("txn reset done");

        // single ALU write: visible exactly two cycles after the offer
        alu_valid = 1'b1; alu_rd = 4'd3; alu_data = 16'h1234;
        cyc();
        alu_valid = 1'b0;
        chk("t1_we_early", rf_we, 1'b0);
        cyc();
        chk("t1_we", rf_we, 1'b1);
        chk("t1_rd", rf_rd, 4'd3);
        chk("t1_wdata", rf_wdata, 16'h1234);
        cyc();
        chk("t1_we_once", rf_we, 1'b0);
        chk("t1_cnt", wr_count, 16'd1);
        $display("txn alu write rd=3 data=1234");

        // load to r0: consumed, never written, not counted
        mem_valid = 1'b1; mem_rd = 4'd0; mem_data = 16'hFFFF;
        cyc();
        mem_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("r0_we", rf_we, 1'b0);
            cyc();
        end
        chk("r0_cnt", wr_count, 16'd1);
        chk("r0_busy", busy, 1'b0);
        $display("txn mem write rd=0 suppressed");

        // both sources streaming
        do_reset();
        seq.delete();
        alu_valid = 1'b1; alu_rd = 4'd1; alu_data = 16'hA001;
        mem_valid = 1'b1; mem_rd = 4'd2; mem_data = 16'hB002;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (rf_we) seq.push_back(rf_rd);
`ifndef RF_WB_ROUND_ROBIN_EN
            if (i == 2) chk("stream_alu_blocked", alu_ready, 1'b0);
`endif
        end
        idle();
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (rf_we) seq.push_back(rf_rd);
        end
        chk("stream_len_ok", seq.size() >= 4, 1'b1);
        if (seq.size() >= 4) begin
`ifdef RF_WB_ROUND_ROBIN_EN
            chk("stream_rr0", seq[0], 4'd2);
            chk("stream_rr1", seq[1], 4'd1);
            chk("stream_rr2", seq[2], 4'd2);
            chk("stream_rr3", seq[3], 4'd1);
`else
            chk("stream_fx0", seq[0], 4'd2);
            chk("stream_fx1", seq[1], 4'd2);
            chk("stream_fx2", seq[2], 4'd2);
            chk("stream_fx3", seq[3], 4'd2);
`endif
        end
        $display("txn stream both sources, %0d writes", seq.size());

        // halt drains four accepted entries, then holds rf_hlt
        do_reset();
        fill_and_halt();
        alu_valid = 1'b1; alu_rd = 4'd9; alu_data = 16'h9999;
        chk("halt_alu_ready", alu_ready, 1'b0);
        chk("halt_mem_ready", mem_ready, 1'b0);
        nwr = 0;
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            if (rf_we) nwr++;
            if (rf_hlt) got = 1'b1;
            else cyc();
        end
        chk("halt_seen", got, 1'b1);
        chk("halt_writes", nwr, 4);
        chk("halt_cnt", wr_count, 16'd4);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("halt_stays", rf_hlt, 1'b1);
            chk("halt_no_accept", alu_ready, 1'b0);
        end
        chk("halt_cnt_final", wr_count, 16'd4);
        idle();
        $display("txn halt drained %0d writes", nwr);

        // reset while draining discards pending entries
        do_reset();
        fill_and_halt();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("mid_we", rf_we, 1'b0);
            chk("mid_hlt", rf_hlt, 1'b0);
            chk("mid_cnt", wr_count, 16'd0);
            chk("mid_alu_ready", alu_ready, 1'b1);
            chk("mid_mem_ready", mem_ready, 1'b1);
            cyc();
        end
        $display("txn reset mid-drain");

        // counter saturation
        do_reset();
        alu_valid = 1'b1; alu_rd = 4'd5; alu_data = 16'h5555;
        repeat (65540) cyc();
        idle();
        repeat (4) cyc();
        chk("sat_cnt", wr_count, 16'hFFFF);
        chk("sat_rd", rf_rd, 4'd5);
        $display("txn saturation wr_count=%0h", wr_count);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
